// File: rtl/seq_divider.sv
// seq_divider
//   Signed sequential divider: a 2N-bit dividend by an N-bit divisor, giving an
//   N-bit quotient (truncated toward zero) and an N-bit remainder. Works on operand
//   magnitudes with a restoring shift-subtract step once per cycle, then applies
//   the signs and saturates in one fix-up cycle.
//
//   Optional feature macro: SEQ_DIVIDER_ROUND_EN
//     When defined, the quotient is rounded to nearest, with ties going away from
//     zero. The remainder output stays the truncated remainder. The latency does
//     not change.
//
//   Ports
//     clk        sole clock, rising edge
//     rst        asynchronous active-high reset
//     in_valid   dividend/divisor presented
//     in_ready   block can accept an operation (IDLE only)
//     dividend   2N-bit signed dividend
//     divisor    N-bit signed divisor
//     out_valid  result valid (DONE only)
//     out_ready  consumer accepts result
//     quotient   N-bit signed quotient
//     remainder  N-bit signed remainder
//     dbz        divide-by-zero flag
//     ovf        quotient overflow / saturation flag
//
//   state | meaning
//   IDLE  | waiting for an operation; in_ready=1
//   CALC  | 2N restoring shift-subtract steps on magnitudes
//   FIX   | apply signs, round (optional), saturate, set flags
//   DONE  | result held until out_ready

module seq_divider #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           dbz,
    output logic           ovf
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(2*N);
    localparam logic [CW-1:0]  LAST_STEP = CW'(2*N-1);
    localparam logic [N-1:0]   Q_MAX     = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]   Q_MIN     = {1'b1, {(N-1){1'b0}}};
    // Largest legal quotient magnitudes. A negative result may reach one further.
    localparam logic [2*N:0]   MAG_POS   = {{(N+2){1'b0}}, {(N-1){1'b1}}};
    localparam logic [2*N:0]   MAG_NEG   = {{(N+1){1'b0}}, 1'b1, {(N-1){1'b0}}};

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  acc_q;   // dividend magnitude, shifted out as quotient bits shift in
    logic [N-1:0]    rem_q;   // partial remainder, always < divisor magnitude
    logic [N-1:0]    dsr_q;   // divisor magnitude
    logic            qneg, rneg;

    logic [2*N-1:0]  dvd_mag;
    logic [N-1:0]    dsr_mag;
    logic [N:0]      shifted;
    logic [N-1:0]    diff;
    logic            take;
    logic [2*N:0]    qm_adj;
    logic [2*N:0]    qlim;
    logic            fix_ovf;
    logic [N-1:0]    q_fix, r_fix;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // -(-2^(2N-1)) wraps to 2^(2N-1), which is still the correct unsigned magnitude.
    assign dvd_mag = dividend[2*N-1] ? -dividend : dividend;
    assign dsr_mag = divisor[N-1]    ? -divisor  : divisor;

    assign shifted = {rem_q, acc_q[2*N-1]};
    assign take    = (shifted >= {1'b0, dsr_q});
    // When a subtraction is taken the true difference is below the divisor, so N bits hold it.
    assign diff    = shifted[N-1:0] - dsr_q;

`ifdef SEQ_DIVIDER_ROUND_EN
    logic round_up;
    assign round_up = ({rem_q, 1'b0} >= {1'b0, dsr_q});
    assign qm_adj   = {1'b0, acc_q} + {{(2*N){1'b0}}, round_up};
`else
    assign qm_adj   = {1'b0, acc_q};
`endif

    assign qlim    = qneg ? MAG_NEG : MAG_POS;
    assign fix_ovf = (qm_adj > qlim);
    assign q_fix   = qneg ? -qm_adj[N-1:0] : qm_adj[N-1:0];
    assign r_fix   = rneg ? -rem_q : rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (divisor == '0) ? DONE : CALC;
            CALC: if (cnt == LAST_STEP) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc_q <= dvd_mag;
                        dsr_q <= dsr_mag;
                        rem_q <= '0;
                        cnt   <= '0;
                        qneg  <= dividend[2*N-1] ^ divisor[N-1];
                        rneg  <= dividend[2*N-1];
                        if (divisor == '0) begin
                            quotient  <= dividend[2*N-1] ? Q_MIN : Q_MAX;
                            remainder <= dividend[N-1:0];
                            dbz       <= 1'b1;
                            ovf       <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    acc_q <= {acc_q[2*N-2:0], take};
                    rem_q <= take ? diff : shifted[N-1:0];
                    cnt   <= cnt + 1'b1;
                end
                FIX: begin
                    quotient  <= fix_ovf ? (qneg ? Q_MIN : Q_MAX) : q_fix;
                    remainder <= fix_ovf ? '0 : r_fix;
                    dbz       <= 1'b0;
                    ovf       <= fix_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Directed checks of seq_divider (N=16): reset values, signed truncation,
//   rounding (when SEQ_DIVIDER_ROUND_EN is defined), overflow saturation,
//   divide-by-zero, result hold under backpressure, back-to-back operations,
//   and an abort by reset in the middle of a computation.

module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        dbz;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SEQ_DIVIDER_ROUND_EN
    localparam int Q_100_8     = 13;
    localparam int Q_M100_8    = -13;
    localparam int Q_65535_2   = 32767;
    localparam int R_65535_2   = 0;
    localparam int O_65535_2   = 1;
`else
    localparam int Q_100_8     = 12;
    localparam int Q_M100_8    = -12;
    localparam int Q_65535_2   = 32767;
    localparam int R_65535_2   = 1;
    localparam int O_65535_2   = 0;
`endif

    seq_divider #(.N(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One full operation: present, accept, scramble the inputs, wait for the
    // result, check it, optionally hold it under backpressure, then release.
    task automatic run(input int a, input int b, input int eq, input int er,
                       input int edbz, input int eovf, input int elat,
                       input int hold, input string tag);
        int lat;
        chk({tag, " in_ready"}, 32'(in_ready), 1);
        dividend = a;
        divisor  = 16'(b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        dividend = ~a;
        divisor  = 16'(b) ^ 16'h5a5a;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " q"}, $signed(quotient), eq);
        chk({tag, " r"}, $signed(remainder), er);
        chk({tag, " dbz"}, 32'(dbz), edbz);
        chk({tag, " ovf"}, 32'(ovf), eovf);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold q"}, $signed(quotient), eq);
            chk({tag, " hold r"}, $signed(remainder), er);
            chk({tag, " hold flags"}, {30'd0, dbz, ovf}, (edbz << 1) | eovf);
            chk({tag, " hold in_ready"}, 32'(in_ready), 0);
            chk({tag, " hold out_valid"}, 32'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " release in_ready"}, 32'(in_ready), 1);
        chk({tag, " release out_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset q", $signed(quotient), 0);
        chk("reset r", $signed(remainder), 0);
        chk("reset flags", {30'd0, dbz, ovf}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(-82814832, -14468, 5724, 0, 0, 0, 34, 0, "prod");
        run(100, 7, 14, 2, 0, 0, 34, 0, "100/7");
        run(-100, 7, -14, -2, 0, 0, 34, 0, "-100/7");
        run(100, -7, -14, 2, 0, 0, 34, 0, "100/-7");
        run(100, 8, Q_100_8, 4, 0, 0, 34, 0, "100/8");
        run(-100, 8, Q_M100_8, -4, 0, 0, 34, 0, "-100/8");
        run(7, 100, 0, 7, 0, 0, 34, 0, "7/100");
        run(32'h40000000, 2, 32767, 0, 0, 1, 34, 0, "ovf_pos");
        run(65536, 2, 32767, 0, 0, 1, 34, 0, "65536/2");
        run(65534, 2, 32767, 0, 0, 0, 34, 0, "65534/2");
        run(-65536, 2, -32768, 0, 0, 0, 34, 0, "-65536/2");
        run(-65538, 2, -32768, 0, 0, 1, 34, 0, "ovf_neg");
        run(65535, 2, Q_65535_2, R_65535_2, 0, O_65535_2, 34, 0, "65535/2");
        run(32'h80000000, -1, 32767, 0, 0, 1, 34, 0, "min/-1");
        run(1000, 0, 32767, 1000, 1, 0, 1, 0, "1000/0");
        run(-5, 0, -32768, -5, 1, 0, 1, 0, "-5/0");
        run(1000, 10, 100, 0, 0, 0, 34, 5, "hold");
        run(-1001, 10, -100, -1, 0, 0, 34, 0, "b2b");

        // Abort by reset at CALC cycle 10; the previous result is still in the
        // output registers, so the reset values below are a real change.
        dividend = 100000;
        divisor  = 16'd8;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort in_ready", 32'(in_ready), 1);
        chk("abort out_valid", 32'(out_valid), 0);
        chk("abort q", $signed(quotient), 0);
        chk("abort r", $signed(remainder), 0);
        chk("abort flags", {30'd0, dbz, ovf}, 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("abort no result", seen, 0);
        run(100000, 8, 12500, 0, 0, 0, 34, 0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: N, 16, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits, all two's-complement signed.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  dividend/divisor presented.
REQ-005 Port: in_ready  output  1  block can accept an operation.
REQ-006 Port: dividend  input  2N  signed dividend (typically a product of two N-bit operands).
REQ-007 Port: divisor  input  N  signed divisor.
REQ-008 Port: out_valid  output  1  result fields valid.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: quotient  output  N  signed quotient.
REQ-011 Port: remainder  output  N  signed remainder.
REQ-012 Port: dbz  output  1  divide-by-zero flag, valid with out_valid.
REQ-013 Port: ovf  output  1  quotient-overflow flag, valid with out_valid.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: on in_valid&in_ready at an edge, operands SHALL be captured; divisor==0 -> DONE, otherwise -> CALC with iteration counter cleared.
REQ-016 CALC SHALL perform one restoring shift-subtract step on operand magnitudes per cycle, exactly 2N cycles, then -> FIX.
REQ-017 FIX SHALL apply signs (quotient negative iff operand signs differ; remainder takes dividend sign), saturate, set flags, then -> DONE.
REQ-018 Latency: out_valid SHALL assert 2N+2 cycles after the accepting edge (34 for N=16); divide-by-zero: 1 cycle.
REQ-019 Truncating division toward zero: dividend == quotient*divisor + remainder, |remainder| < |divisor|.
REQ-020 Overflow: if the true quotient is outside [-2^(N-1), 2^(N-1)-1], ovf=1, quotient saturates to 2^(N-1)-1 (positive) or -2^(N-1) (negative), remainder=0.
REQ-021 Divide-by-zero: dbz=1, ovf=0, quotient = 2^(N-1)-1 if dividend>=0 else -2^(N-1), remainder = dividend[N-1:0].
REQ-022 DONE: quotient/remainder/dbz/ovf SHALL be held stable while out_ready=0; on out_ready=1 -> IDLE (in_ready=1 next cycle); no acceptance in DONE.
REQ-023 in_valid outside IDLE and operand changes after capture SHALL be ignored.

Reset
REQ-024 rst=1 SHALL immediately force IDLE and in_ready=1, out_valid=0, quotient=0, remainder=0, dbz=0, ovf=0, internal registers 0.
REQ-025 rst asserted in CALC/FIX/DONE SHALL abort the operation; no result is emitted afterwards.

Configuration
REQ-026 Macro SEQ_DIVIDER_ROUND_EN defined: FIX SHALL round quotient to nearest (ties away from zero) using 2|r| >= |divisor|; remainder output stays the truncated remainder; rounding past range sets ovf and saturates per REQ-020; latency unchanged.
REQ-027 Macro undefined: quotient is truncated toward zero per REQ-019; no rounding logic synthesized.

Verification
REQ-028 dividend=-82814832, divisor=-14468 -> after 34 cycles quotient=5724, remainder=0, dbz=0, ovf=0.
REQ-029 100/7 -> q=14 r=2; -100/7 -> q=-14 r=-2; 100/-7 -> q=-14 r=2.
REQ-030 100/8 -> q=12 r=4 without SEQ_DIVIDER_ROUND_EN, q=13 r=4 with it; -100/8 -> -12 / -13 respectively.
REQ-031 32'h40000000/2 -> ovf=1, q=32767, r=0; 1000/0 -> dbz=1, q=32767, r=1000 one cycle after accept; -5/0 -> q=-32768, r=-5.
REQ-032 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; then 1 -> in_ready=1 next cycle, back-to-back op accepted.
REQ-033 rst pulsed at CALC cycle 10 -> all outputs 0, in_ready=1 immediately, next operation produces correct result at normal latency.
